// File: rtl/ternary_pkg.sv
// Shared constants and types for the ternary matrix-vector controller.
// The weight-code and width constants are the reference values for the multiplier.
package ternary_pkg;
  localparam int IN_LEN    = 16;
  localparam int OUT_LEN   = 8;
  localparam int BIT_WIDTH = 8;

  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_NEG  = 2'b11;
  localparam logic [1:0] W_ZERO = 2'b00;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Travels with each multiplier strobe until its result is registered.
  typedef struct packed {
    logic [2:0] idx;
    logic       sup;
    logic       last;
  } beat_tag_t;
endpackage

// File: rtl/ternary_wbuf.sv
// Ternary weight array plus its byte loader.
// Byte b lands on bits [b*8 +: 8], i.e. row b/2, columns (b%2)*4..+3.
module ternary_wbuf
  import ternary_pkg::*;
#(
  parameter int InLen  = IN_LEN,
  parameter int OutLen = OUT_LEN
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr,
  input  logic [7:0]                wbyte,
  output logic [2*InLen*OutLen-1:0] w,
  output logic                      loaded
);
  localparam int NBYTES = InLen * OutLen / 4;
  localparam int CW     = $clog2(NBYTES);

  logic [CW-1:0] cnt;

  // The counter wraps after the last byte so a reload refills from row 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      w      <= '0;
      loaded <= 1'b0;
    end else if (wr) begin
      w[{cnt, 3'b000} +: 8] <= wbyte;
      cnt                   <= cnt + 1'b1;
      if (cnt == CW'(NBYTES - 1)) loaded <= 1'b1;
    end
  end
endmodule

// File: rtl/ternary_mv_ctrl.sv
// Feeds element pairs to an external ternary multiplier and returns its results.
// One pass is 8 beats; results lag one pass, hence first-pass suppression and DRAIN.
module ternary_mv_ctrl
  import ternary_pkg::*;
#(
  parameter int InLen    = IN_LEN,
  parameter int OutLen   = OUT_LEN,
  parameter int BitWidth = BIT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BitWidth-1:0]       in_data,
  input  logic                      in_kind,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BitWidth-1:0]       out_data,
  output logic [2:0]                out_idx,
  output logic                      out_last,
  output logic                      busy,
  output logic                      mult_en,
  output logic [BitWidth-1:0]       mult_vec0,
  output logic [BitWidth-1:0]       mult_vec1,
  output logic [2*InLen*OutLen-1:0] mult_w,
  input  logic [BitWidth-1:0]       mult_vec_out
);
  state_t     state;
  beat_tag_t  tag;
  logic [2:0] beat;
  logic       alive, w_loaded, pair_full, odd, pair_last, first_pass, drain_done;
  logic       w_acc, e_acc, out_hs, pend, issue;

  // alive keeps in_ready low while reset is asserted.
  assign in_ready = alive && (in_kind ? (state == IDLE)
                                      : (w_loaded && !pair_full && state != DRAIN));
  assign w_acc    = in_valid && in_ready && in_kind;
  assign e_acc    = in_valid && in_ready && !in_kind;
  assign out_hs   = out_valid && out_ready;
  assign pend     = (state == RUN && pair_full) || (state == DRAIN && !drain_done);
  // !mult_en: the previous result must be registered before the multiplier overwrites it.
  assign issue    = pend && !mult_en && (!out_valid || out_ready);
  assign busy     = state != IDLE;
  assign out_data = mult_vec_out;

  ternary_wbuf #(.InLen(InLen), .OutLen(OutLen)) u_wbuf (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr     (w_acc),
    .wbyte  (in_data[7:0]),
    .w      (mult_w),
    .loaded (w_loaded)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tag        <= '0;
      beat       <= '0;
      alive      <= 1'b0;
      pair_full  <= 1'b0;
      odd        <= 1'b0;
      pair_last  <= 1'b0;
      first_pass <= 1'b0;
      drain_done <= 1'b0;
      mult_en    <= 1'b0;
      mult_vec0  <= '0;
      mult_vec1  <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_last   <= 1'b0;
    end else begin
      alive   <= 1'b1;
      mult_en <= issue;

      if (e_acc) begin
        if (!odd) mult_vec0 <= in_data;
        else begin
          mult_vec1 <= in_data;
          pair_full <= 1'b1;
          pair_last <= in_last;
        end
        odd <= ~odd;
      end

      if (issue) begin
        tag  <= '{idx: beat, sup: first_pass, last: (state == DRAIN) && (beat == 3'd7)};
        beat <= beat + 3'd1;
      end

      if (mult_en && !tag.sup) begin
        out_valid <= 1'b1;
        out_idx   <= tag.idx;
        out_last  <= tag.last;
      end else if (out_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      case (state)
        IDLE: if (e_acc) begin
          state      <= RUN;
          first_pass <= 1'b1;
        end
        RUN: if (issue) begin
          pair_full <= 1'b0;
          if (beat == 3'd7) begin
            first_pass <= 1'b0;
            if (pair_last) begin
              state     <= DRAIN;
              pair_last <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Hold the final pair through its strobe, then feed zeros.
          if (!mult_en) begin
            mult_vec0 <= '0;
            mult_vec1 <= '0;
          end
          if (issue && beat == 3'd7) drain_done <= 1'b1;
          if (out_hs && out_last) begin
            state      <= IDLE;
            drain_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ternary_mv_ctrl.sv
// Bench for ternary_mv_ctrl: a pass-lagged multiplier fixture plus a direct dot-product model.
module tb_ternary_mv_ctrl;
  import ternary_pkg::*;
  localparam int NW = 2 * IN_LEN * OUT_LEN;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_kind = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic in_ready, out_valid, out_last, busy, mult_en;
  logic [7:0] out_data, mult_vec0, mult_vec1, mvo;
  logic [2:0] out_idx;
  logic [NW-1:0] mult_w;

  int n_vec = 0, n_err = 0, rdy_mode = 0, mult_en_cnt = 0;
  logic [11:0] got_q[$], exp_q[$];
  logic [7:0]  wbytes[32];
  logic [7:0]  vbuf[$];

  ternary_mv_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_kind(in_kind), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .busy(busy), .mult_en(mult_en),
    .mult_vec0(mult_vec0), .mult_vec1(mult_vec1), .mult_w(mult_w), .mult_vec_out(mvo)
  );

  always #5 clk = ~clk;

  // Multiplier fixture: accumulates two rows per beat, emits the previous pass's column.
  logic [7:0] acc[8], prv[8];
  logic [2:0] row;
  function automatic int cv(input logic [1:0] code);
    return (code == 2'b01) ? 1 : (code == 2'b11) ? -1 : 0;
  endfunction
  function automatic logic [7:0] mac(input int c);
    int s;
    s = cv(mult_w[(int'(row) * 16 + c) * 2 +: 2]) * int'($signed(mult_vec0))
      + cv(mult_w[((int'(row) * 2 + 1) * 8 + c) * 2 +: 2]) * int'($signed(mult_vec1));
    return acc[c] + 8'(s);
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= 3'd0;
      mvo <= 8'h00;
      for (int c = 0; c < 8; c++) begin acc[c] <= 8'h00; prv[c] <= 8'h00; end
    end else if (mult_en) begin
      mvo <= prv[row];
      for (int c = 0; c < 8; c++) begin
        if (row == 3'd7) begin prv[c] <= mac(c); acc[c] <= 8'h00; end
        else acc[c] <= mac(c);
      end
      row <= row + 3'd1;
    end
  end

  initial forever begin
    @(negedge clk); #1;
    out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  initial forever begin
    @(negedge clk); #2;
    if (rst_n && out_valid && out_ready) got_q.push_back({out_last, out_idx, out_data});
    if (mult_en) mult_en_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int wcode(input int r, input int c);
    logic [7:0] b;
    logic [1:0] code;
    b = wbytes[r * 2 + c / 4];
    code = b[(c % 4) * 2 +: 2];
    return (code == 2'b01) ? 1 : (code == 2'b11) ? -1 : 0;
  endfunction
  function automatic logic [7:0] ref_dot(input int base, input int c);
    int s = 0;
    for (int r = 0; r < 16; r++) s += wcode(r, c) * int'($signed(vbuf[base + r]));
    return 8'(s);
  endfunction
  function automatic logic [NW-1:0] exp_w();
    logic [NW-1:0] w = '0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 8; c++) begin
        logic [7:0] b;
        b = wbytes[r * 2 + c / 4];
        w[(r * 8 + c) * 2 +: 2] = b[(c % 4) * 2 +: 2];
      end
    return w;
  endfunction
  function automatic void push_run_expect(input int base, input int nv);
    for (int k = 0; k < nv; k++)
      for (int c = 0; c < 8; c++)
        exp_q.push_back({(k == nv - 1) && (c == 7), 3'(c), ref_dot(base + 16 * k, c)});
  endfunction

  // ---------------- drivers ----------------
  task automatic send(input logic k, input logic [7:0] d, input logic l, output bit ok);
    @(negedge clk);
    in_valid = 1'b1; in_kind = k; in_data = d; in_last = l; ok = 1'b0;
    #1;
    for (int t = 0; t < 400; t++) begin
      if (in_ready) begin ok = 1'b1; @(posedge clk); break; end
      @(negedge clk); #1;
    end
  endtask
  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask
  task automatic load_w(output int bad);
    bit ok;
    bad = 0;
    for (int b = 0; b < 32; b++) begin send(1'b1, wbytes[b], 1'b0, ok); if (!ok) bad++; end
    idle_in();
  endtask
  task automatic stream(input int base, input int n, input bit tl, output int bad);
    bit ok;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      send(1'b0, vbuf[base + i], tl && (i == n - 1), ok);
      if (!ok) bad++;
    end
    idle_in();
  endtask
  task automatic wait_done(input int n, output bit to);
    to = 1'b1;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk); #3;
      if (got_q.size() >= n && !busy) begin to = 1'b0; break; end
    end
    repeat (6) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_kind = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    n_vec++;
    if ({busy, mult_en, out_valid, out_last, in_ready} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctl got %b want 00000", {busy, mult_en, out_valid, out_last, in_ready});
    end
    n_vec++;
    if (mult_w !== '0) begin n_err++; $display("FAIL reset_w got %h want 0", mult_w); end
    n_vec++;
    if ({mult_vec0, mult_vec1} !== 16'h0) begin
      n_err++; $display("FAIL reset_vec got %h want 0000", {mult_vec0, mult_vec1});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_wready got %b want 1", in_ready); end
    in_kind = 1'b0;
  endtask

  task automatic test_order();
    bit seen, to;
    bit ok;
    int bad;
    logic [NW-1:0] w0;
    rdy_mode = 0; got_q.delete(); exp_q.delete();
    @(negedge clk);
    in_valid = 1'b1; in_kind = 1'b0; in_data = 8'h11; #1; seen = 1'b0;
    repeat (4) begin if (in_ready) seen = 1'b1; @(negedge clk); #1; end
    idle_in();
    n_vec++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL elem_before_w ready got %b want 0", seen); end
    for (int b = 0; b < 32; b++) wbytes[b] = 8'($urandom);
    load_w(bad);
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL order_wload refused got %0d want 0", bad); end
    w0 = exp_w();
    n_vec++;
    if (mult_w !== w0) begin n_err++; $display("FAIL order_wmap got %h want %h", mult_w, w0); end
    vbuf.delete();
    for (int i = 0; i < 16; i++) vbuf.push_back(8'($urandom));
    push_run_expect(0, 1);
    send(1'b0, vbuf[0], 1'b0, ok);
    @(negedge clk);
    in_valid = 1'b1; in_kind = 1'b1; in_data = 8'($urandom); #1; seen = 1'b0;
    repeat (4) begin if (in_ready) seen = 1'b1; @(negedge clk); #1; end
    idle_in();
    n_vec++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL w_in_run ready got %b want 0", seen); end
    n_vec++;
    if (mult_w !== w0) begin n_err++; $display("FAIL w_in_run mult_w got %h want %h", mult_w, w0); end
    stream(1, 15, 1'b1, bad);
    wait_done(8, to);
    n_vec++;
    if ({to, got_q.size()} !== {1'b0, 32'(exp_q.size())}) begin
      n_err++; $display("FAIL order_count got %0d timeout %b want %0d", got_q.size(), to, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL order_res[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_pos();
    int bad;
    bit to;
    rdy_mode = 1; got_q.delete(); exp_q.delete();
    for (int b = 0; b < 32; b++) wbytes[b] = 8'h55;
    load_w(bad);
    vbuf.delete();
    for (int i = 1; i <= 16; i++) vbuf.push_back(8'(i));
    for (int c = 0; c < 8; c++) exp_q.push_back({c == 7, 3'(c), 8'h88});
    stream(0, 16, 1'b1, bad);
    wait_done(8, to);
    n_vec++;
    if ({to, got_q.size()} !== {1'b0, 32'd8}) begin
      n_err++; $display("FAIL pos_count got %0d timeout %b want 8", got_q.size(), to);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL pos_res[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_neg();
    int bad;
    bit to;
    rdy_mode = 1;
    for (int run = 0; run < 2; run++) begin
      got_q.delete(); exp_q.delete();
      if (run == 0) begin
        for (int b = 0; b < 32; b++) wbytes[b] = 8'hFF;
        load_w(bad);
      end
      vbuf.delete();
      for (int i = 0; i < 16; i++) vbuf.push_back((run == 0) ? 8'd3 : 8'd0);
      for (int c = 0; c < 8; c++) exp_q.push_back({c == 7, 3'(c), (run == 0) ? 8'hD0 : 8'h00});
      stream(0, 16, 1'b1, bad);
      wait_done(8, to);
      n_vec++;
      if ({to, got_q.size()} !== {1'b0, 32'd8}) begin
        n_err++; $display("FAIL neg%0d_count got %0d timeout %b want 8", run, got_q.size(), to);
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL neg%0d_res[%0d] got %h want %h", run, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_random();
    int bad;
    bit to;
    rdy_mode = 1;
    for (int it = 0; it < 2; it++) begin
      got_q.delete(); exp_q.delete();
      for (int b = 0; b < 32; b++) wbytes[b] = 8'($urandom);
      load_w(bad);
      vbuf.delete();
      for (int i = 0; i < 48; i++) vbuf.push_back(8'($urandom));
      push_run_expect(0, 3);
      stream(0, 48, 1'b1, bad);
      wait_done(24, to);
      n_vec++;
      if ({to, bad, got_q.size()} !== {1'b0, 32'd0, 32'd24}) begin
        n_err++; $display("FAIL rand%0d_count got %0d refused %0d timeout %b want 24", it, got_q.size(), bad, to);
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_res[%0d] got %h want %h", it, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int bad, c0, stalls;
    bit to, seen;
    got_q.delete(); exp_q.delete();
    rdy_mode = 1;
    for (int b = 0; b < 32; b++) wbytes[b] = 8'($urandom);
    load_w(bad);
    vbuf.delete();
    for (int i = 0; i < 48; i++) vbuf.push_back(8'($urandom));
    push_run_expect(0, 3);
    rdy_mode = 2;
    repeat (2) @(negedge clk);
    fork
      stream(0, 48, 1'b1, bad);
      begin
        seen = 1'b0;
        for (int t = 0; t < 1000; t++) begin
          @(negedge clk); #3;
          if (out_valid) begin seen = 1'b1; break; end
        end
        c0 = mult_en_cnt;
        repeat (20) @(negedge clk);
        #3;
        stalls = mult_en_cnt - c0;
        n_vec++;
        if ({seen, stalls} !== {1'b1, 32'd0}) begin
          n_err++; $display("FAIL bp_hold mult_en pulses %0d seen %b want 0 and 1", stalls, seen);
        end
        n_vec++;
        if ({out_valid, in_ready, got_q.size()} !== {1'b1, 1'b0, 32'd0}) begin
          n_err++; $display("FAIL bp_state valid %b ready %b taken %0d want 1 0 0", out_valid, in_ready, got_q.size());
        end
        rdy_mode = 1;
      end
    join
    wait_done(24, to);
    n_vec++;
    if ({to, got_q.size()} !== {1'b0, 32'd24}) begin
      n_err++; $display("FAIL bp_count got %0d timeout %b want 24", got_q.size(), to);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_res[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int bad, c0;
    bit to, seen;
    rdy_mode = 0; got_q.delete(); exp_q.delete();
    for (int b = 0; b < 32; b++) wbytes[b] = 8'($urandom);
    load_w(bad);
    vbuf.delete();
    for (int i = 0; i < 32; i++) vbuf.push_back(8'($urandom));
    c0 = mult_en_cnt;
    stream(0, 12, 1'b0, bad);
    seen = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk); #3;
      if (mult_en_cnt - c0 >= 6) begin seen = 1'b1; break; end
    end
    n_vec++;
    if (seen !== 1'b1) begin n_err++; $display("FAIL rm_beat5 strobes %0d want 6", mult_en_cnt - c0); end
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    n_vec++;
    if ({busy, mult_en, out_valid, out_last, in_ready} !== 5'b0) begin
      n_err++; $display("FAIL rm_ctl got %b want 00000", {busy, mult_en, out_valid, out_last, in_ready});
    end
    n_vec++;
    if ({mult_w == '0, mult_vec0, mult_vec1} !== {1'b1, 16'h0}) begin
      n_err++; $display("FAIL rm_data wzero %b vec %h want 1 0000", mult_w == '0, {mult_vec0, mult_vec1});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_q.delete(); exp_q.delete();
    for (int b = 0; b < 32; b++) wbytes[b] = 8'($urandom);
    load_w(bad);
    push_run_expect(0, 2);
    stream(0, 32, 1'b1, bad);
    wait_done(16, to);
    n_vec++;
    if ({to, got_q.size()} !== {1'b0, 32'd16}) begin
      n_err++; $display("FAIL rm_count got %0d timeout %b want 16", got_q.size(), to);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rm_res[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_pos();
    test_neg();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
